issue_group_sequencer: RTL
==========================

// Module: issue_group_sequencer
// PURPOSE
//  In-order instruction queue between fetch and the 3-wide ID/hazard-detection stage.
//  Buffers fetched groups and presents the oldest WAYS entries to ID each cycle.
//  Retires the prefix the hazard detection unit accepts (accept_cnt) and holds the rest.
//  Held entries are re-presented, shifted to slot 0, next cycle; squash empties the queue.
// PARAMETERS
//  WAYS    3  issue width, slots per fetch group and per ID group
//  QDEPTH  8  queue entries; power of two, >= 2*WAYS
// PORTS
//  clock        in   1             system clock, rising edge
//  reset        in   1             asynchronous, active-high reset
//  squash       in   1             sync flush (branch mispredict / rollback to fetch)
//  fetch_valid  in   WAYS          per-slot valid of fetch group, slot 0 oldest
//  fetch_inst   in   WAYS*32       fetched instructions, slot i at [32*i+:32]
//  fetch_pc     in   WAYS*32       PCs of fetched instructions
//  fetch_ready  out  1             queue can take a full group this cycle
//  id_valid     out  WAYS          slot i holds a valid queued instruction
//  id_inst      out  WAYS*32       queue entries head..head+WAYS-1
//  id_pc        out  WAYS*32       PCs of presented entries
//  accept_cnt   in   $clog2(WAYS+1) in-order count ID/detection takes this cycle
//  id_stall     out  1             valid slots presented but not all accepted
// BEHAVIOUR
//  - State: entry array, head, tail ($clog2(QDEPTH) bits, wrap mod QDEPTH), count (0..QDEPTH).
//  - Reset (async): head=tail=count=0, entries=0; id_valid=0, id_inst=0, id_pc=0,
//    id_stall=0; fetch_ready=0 while reset high, 1 after release.
//  - fetch_ready = !reset && !squash && (QDEPTH-count >= WAYS); registered count only,
//    no credit for same-cycle pop.
//  - Enqueue on posedge when fetch_ready && fetch_valid!=0: n_enq = leading-ones of
//    fetch_valid from slot 0; bits above first 0 ignored. Slot k written at tail+k; tail+=n_enq.
//  - Presentation (comb from state): id_valid[i]=(count>i); id_inst/id_pc[i]=entry[(head+i)%QDEPTH];
//    invalid slots drive inst=0, pc=0.
//  - Pop: n_pop = min(accept_cnt, count, WAYS); head+=n_pop on posedge.
//  - count_next = count + n_enq - n_pop; simultaneous enqueue/pop always legal.
//  - Latency: group enqueued at edge N is visible on id_* in cycle N+1 (empty queue).
//  - id_stall = (count>0) && (accept_cnt < min(count,WAYS)).
//  - Squash: next state head=tail=count=0; enqueue and pop of that cycle discarded.
//  - Entry contents never cleared except by reset; validity is from count only.
//  - Full: count=QDEPTH-WAYS+1..QDEPTH -> fetch_ready=0; fetch_valid is don't-care then.
//  - accept_cnt>count must not corrupt state (clamped); assertion flags it in simulation.
// CONFIGURATION
//  ISSUE_SEQ_PERF_EN defined: adds outputs perf_issued[31:0] (sum of n_pop) and
//    perf_stall_cycles[31:0] (cycles with id_stall=1); async reset to 0, wrap at 2^32,
//    not cleared by squash.
//  Undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
//  1 Reset mid-run (count=5) -> same cycle id_valid=000, fetch_ready=0; after release fetch_ready=1.
//  2 Fetch {00108093,00210113,00318193} valid=111, accept=0 -> next cycle id_valid=111 in order,
//    id_stall=1; then accept=3 -> id_valid=000, count=0.
//  3 Partial accept: 3 queued, accept=1 -> next cycle slot0=00210113, slot1=00318193,
//    slot2 from next group if enqueued, else id_valid=011.
//  4 Wrap: fill with accept=0 until fetch_ready=0 (count 6), pop 3, refill 3 ->
//    tail wraps past entry 7, order preserved, count=6.
//  5 Squash with fetch_valid=111 and accept=2 same cycle -> next cycle count=0,
//    id_valid=000, no entry enqueued.
//  6 fetch_valid=101 -> only slot 0 enqueued (count+1); with ISSUE_SEQ_PERF_EN
//    perf_issued/perf_stall_cycles match bench-side tallies after 20-cycle random run.

Source files
------------

// File: rtl/issue_group_sequencer.sv
// In-order issue queue between fetch and the WAYS-wide ID/hazard stage.
// Define ISSUE_SEQ_PERF_EN to add the perf_issued / perf_stall_cycles counters.
module issue_group_sequencer #(
   parameter int WAYS   = 3,
   parameter int QDEPTH = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      squash,
   input  logic [WAYS-1:0]           fetch_valid,
   input  logic [WAYS*32-1:0]        fetch_inst,
   input  logic [WAYS*32-1:0]        fetch_pc,
   output logic                      fetch_ready,
   output logic [WAYS-1:0]           id_valid,
   output logic [WAYS*32-1:0]        id_inst,
   output logic [WAYS*32-1:0]        id_pc,
   input  logic [$clog2(WAYS+1)-1:0] accept_cnt,
`ifdef ISSUE_SEQ_PERF_EN
   output logic [31:0]               perf_issued,
   output logic [31:0]               perf_stall_cycles,
`endif
   output logic                      id_stall
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH+1);
   localparam int NW = $clog2(WAYS+1);

   logic [31:0]   inst_q [QDEPTH];
   logic [31:0]   pc_q   [QDEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;

   logic [NW-1:0] n_enq;
   logic [NW-1:0] n_pop;
   logic          do_enq;
   logic [CW-1:0] avail;
   logic [CW-1:0] acc_ext;
   logic [CW-1:0] pop_lim;
   logic          run;

   assign fetch_ready = !reset && !squash
                      && ((CW'(QDEPTH) - count) >= CW'(WAYS));

   // Only the contiguous run of valid slots starting at slot 0 counts.
   always_comb begin
      n_enq = '0;
      run   = 1'b1;
      for (int i = 0; i < WAYS; i++) begin
         if (run && fetch_valid[i])
            n_enq = NW'(i + 1);
         else
            run = 1'b0;
      end
   end

   assign do_enq = fetch_ready && (n_enq != '0);

   always_comb begin
      avail   = (count < CW'(WAYS)) ? count : CW'(WAYS);
      acc_ext = CW'(accept_cnt);
      pop_lim = (acc_ext < avail) ? acc_ext : avail;
      n_pop   = NW'(pop_lim);
      id_stall = (count != '0) && (acc_ext < avail);
   end

   always_comb begin
      id_valid = '0;
      id_inst  = '0;
      id_pc    = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (count > CW'(i)) begin
            id_valid[i]       = 1'b1;
            id_inst[32*i+:32] = inst_q[head + AW'(i)];
            id_pc[32*i+:32]   = pc_q[head + AW'(i)];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int k = 0; k < QDEPTH; k++) begin
            inst_q[k] <= '0;
            pc_q[k]   <= '0;
         end
      end else if (squash) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_enq) begin
            for (int k = 0; k < WAYS; k++) begin
               if (k < int'(n_enq)) begin
                  inst_q[tail + AW'(k)] <= fetch_inst[32*k+:32];
                  pc_q[tail + AW'(k)]   <= fetch_pc[32*k+:32];
               end
            end
            tail <= tail + AW'(n_enq);
         end
         head  <= head + AW'(n_pop);
         count <= count + (do_enq ? CW'(n_enq) : '0) - CW'(n_pop);
      end
   end

`ifdef ISSUE_SEQ_PERF_EN
   // Squashed pops never reach ID, so they are not counted as issued.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_issued       <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (!squash)
            perf_issued <= perf_issued + 32'(n_pop);
         if (id_stall)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

   accept_le_count: assert property (
      @(posedge clock) disable iff (reset)
      CW'(accept_cnt) <= count
   ) else $error("accept_cnt exceeds queue occupancy");

endmodule
